// File: rtl/aes_serial_sched_pkg.sv
// Shared types and sizes for the serial AES core sequencer.
package aes_serial_sched_pkg;

  localparam int unsigned BLOCK_BITS       = 128;
  localparam int unsigned KEY_BITS         = 128;
  localparam int unsigned SERIAL_LOAD_BITS = BLOCK_BITS + KEY_BITS;
  // Wide enough for the longest phase (LEAD_CYC + 256) without wrapping.
  localparam int unsigned CNT_W            = 9;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StWait,
    StRead,
    StResp
  } state_e;

endpackage

// File: rtl/aes_serial_sched_if.sv
// Request/response handshake bundle between the bus logic and the sequencer.
interface aes_serial_sched_if;
  import aes_serial_sched_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_mode;
  logic [BLOCK_BITS-1:0] req_data;
  logic [KEY_BITS-1:0]   req_key;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [BLOCK_BITS-1:0] rsp_data;
  logic                  rsp_mode;

  // Requester side.
  modport master (
    output req_valid, req_mode, req_data, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_mode
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_mode, req_data, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_mode
  );

endinterface

// File: rtl/aes_serial_sched_serdes.sv
// LSB-first 256-bit shift-out and 128-bit shift-in for the serial cores.
module aes_serial_sched_serdes
  import aes_serial_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [SERIAL_LOAD_BITS-1:0] load_data_i,
  input  logic                        shift_i,
  input  logic                        capture_i,
  input  logic                        serial_i,
  output logic                        serial_o,
  output logic [BLOCK_BITS-1:0]       rx_next_o
);

  logic [SERIAL_LOAD_BITS-1:0] tx_q;
  // One bit short of a block: the final bit is merged in rx_next_o when the caller latches it.
  logic [BLOCK_BITS-2:0]       rx_q;

  assign serial_o  = tx_q[0];
  assign rx_next_o = {serial_i, rx_q};

  // Transmit register: parallel load, then shift towards bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
    end else if (load_i) begin
      tx_q <= load_data_i;
    end else if (shift_i) begin
      tx_q <= {1'b0, tx_q[SERIAL_LOAD_BITS-1:1]};
    end
  end

  // Receive register: new bits enter at the top so the first bit ends at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
    end else if (capture_i) begin
      rx_q <= rx_next_o[BLOCK_BITS-1:1];
    end
  end

endmodule

// File: rtl/aes_serial_sched.sv
// Sequencer driving the bit-serial AES encrypt/decrypt cores for one requester.
module aes_serial_sched
  import aes_serial_sched_pkg::*;
#(
  parameter int unsigned LEAD_CYC = 1,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned WAIT_CYC = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  aes_serial_sched_if.slave        bus,
  output logic                     busy,
  output logic                     cs_enc,
  output logic                     miso_enc,
  input  logic                     mosi_enc,
  output logic                     cs_dec,
  output logic                     miso_dec,
  input  logic                     mosi_dec
);

  localparam logic [CNT_W-1:0] Lead     = CNT_W'(LEAD_CYC);
  localparam logic [CNT_W-1:0] LoadLast = CNT_W'(LEAD_CYC + SERIAL_LOAD_BITS - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] ReadLast = CNT_W'(LEAD_CYC + BLOCK_BITS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q;
  logic [BLOCK_BITS-1:0] rsp_data_q;
  logic                  rsp_mode_q;

  logic                  load_en, shift_en, capture_en, rsp_load;
  logic                  bit_slot, phase_act, miso_act;
  logic                  serial_out, serial_in;
  logic [BLOCK_BITS-1:0] rx_next;

  // Lead cycles carry no data; bit k lives in phase cycle Lead + k.
  assign bit_slot = (cnt_q >= Lead);

  aes_serial_sched_serdes u_serdes (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_en),
    .load_data_i ({bus.req_key, bus.req_data}),
    .shift_i     (shift_en),
    .capture_i   (capture_en),
    .serial_i    (serial_in),
    .serial_o    (serial_out),
    .rx_next_o   (rx_next)
  );

  // Next-state, phase counter and serdes strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    load_en    = 1'b0;
    shift_en   = 1'b0;
    capture_en = 1'b0;
    rsp_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          load_en = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        shift_en = bit_slot;
        if (cnt_q == LoadLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StRead;
          cnt_d   = '0;
        end
      end
      StRead: begin
        capture_en = bit_slot;
        if (cnt_q == ReadLast) begin
          rsp_load = 1'b1;
          state_d  = StResp;
          cnt_d    = '0;
        end
      end
      StResp: begin
        cnt_d = '0;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latched mode and response holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mode_q     <= MODE_ENC;
      rsp_data_q <= '0;
      rsp_mode_q <= MODE_ENC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_en) begin
        mode_q <= bus.req_mode;
      end
      if (rsp_load) begin
        rsp_data_q <= rx_next;
        rsp_mode_q <= mode_q;
      end
    end
  end

  // Core pin muxing: the unselected core sees cs and miso held low throughout.
  assign phase_act = (state_q == StLoad) || (state_q == StRead);
  assign miso_act  = (state_q == StLoad) && bit_slot && serial_out;
  assign cs_enc    = phase_act && (mode_q == MODE_ENC);
  assign cs_dec    = phase_act && (mode_q == MODE_DEC);
  assign miso_enc  = miso_act && (mode_q == MODE_ENC);
  assign miso_dec  = miso_act && (mode_q == MODE_DEC);
  assign serial_in = (mode_q == MODE_DEC) ? mosi_dec : mosi_enc;

  assign busy          = (state_q != StIdle);
  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_mode  = rsp_mode_q;

endmodule
